merge_run_sequencer: RTL and testbench

Run-boundary controller between the two input FIFOs and the MERGER in a merge-sort stage.
- Each input FIFO carries back-to-back sorted runs of i_run_len elements.
- The sequencer gates the FIFO interfaces so the merger merges exactly one run pair at a time and never crosses run boundaries.
- It counts merger output writes to detect run-pair completion, then advances through i_num_runs run pairs and reports done.

---
 rtl/merge_run_sequencer_pkg.sv | 23 ++
 rtl/merge_run_sequencer_side_gate.sv | 81 ++++++++
 rtl/merge_run_sequencer.sv | 179 +++++++++++++++++
 tb/tb_merge_run_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_run_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// merge_pkg
// Shared constants and types for the merge-sort run sequencer.
//   DATA_W_DEF   : default item width
//   CNT_W_DEF    : default width of run-length / element / run counters
//   SENTINEL_DEF : all-ones key shown to the merger for an exhausted side
//   state_t      : sequencer FSM states
// ---------------------------------------------------------------------------
package merge_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   localparam logic [DATA_W_DEF-1:0] SENTINEL_DEF = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MERGE = 2'd1,
      NEXT  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/merge_run_sequencer_side_gate.sv
// ---------------------------------------------------------------------------
// run_side_gate
// Gates one input FIFO towards one merger input so that exactly run_len
// elements of the current run are handed over, then shows SENTINEL (while
// the other side is still active) or empty (when both sides are done).
//
// Handshake: fifo_item/fifo_empty form a first-word fall-through head; an
// element moves when mrg_read is high on a clock edge while mrg_empty is low.
// fifo_read is a combinational copy of mrg_read for the active side only.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   run_len         elements per run on this side
//   clear           zero the element counter (new run pair)
//   enable          sequencer is in MERGE
//   other_active    the opposite side still has elements left in this run
//   fifo_item/empty FIFO head;  fifo_read  pop strobe to the FIFO
//   mrg_item/empty  view presented to the merger;  mrg_read  merger strobe
//   active          this side still has elements left in this run
//   err             protocol violation seen this cycle
// ---------------------------------------------------------------------------
module run_side_gate
   import merge_pkg::*;
#(
   parameter int                 DATA_W   = DATA_W_DEF,
   parameter int                 CNT_W    = CNT_W_DEF,
   parameter logic [DATA_W-1:0]  SENTINEL = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CNT_W-1:0]  run_len,
   input  logic              clear,
   input  logic              enable,
   input  logic              other_active,
   input  logic [DATA_W-1:0] fifo_item,
   input  logic              fifo_empty,
   output logic              fifo_read,
   output logic [DATA_W-1:0] mrg_item,
   output logic              mrg_empty,
   input  logic              mrg_read,
   output logic              active,
   output logic              err
);

   logic [CNT_W-1:0] cnt;

   assign active = (cnt < run_len);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && active && mrg_read) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_comb begin
      mrg_item  = '0;
      mrg_empty = 1'b1;
      fifo_read = 1'b0;
      if (enable) begin
         if (active) begin
            mrg_item  = fifo_item;
            mrg_empty = fifo_empty;
            fifo_read = mrg_read;
         end else if (other_active) begin
            // Exhausted side looks like an endless supply of "infinity" so
            // the merger keeps draining the other side of the pair.
            mrg_item  = SENTINEL;
            mrg_empty = 1'b0;
         end
      end
   end

   // Reading an empty view covers the active-side read-while-FIFO-empty case
   // too, since the active view passes the FIFO empty flag straight through.
   assign err = mrg_read && (mrg_empty || (enable && active && fifo_empty));

endmodule

// File: rtl/merge_run_sequencer.sv
// ---------------------------------------------------------------------------
// merge_run_sequencer
// Run-boundary controller between two input FIFOs and a two-way merger.
// Each FIFO carries back-to-back sorted runs of run_len elements; the
// sequencer lets the merger see exactly one run pair at a time, counts the
// merger's output writes to detect pair completion, steps through num_runs
// pairs and pulses o_done.
//
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_start, i_run_len, i_num_runs     job start (honoured in IDLE only)
//   i_fifo_k_item/empty, o_fifo_k_read FIFO k head and pop strobe
//   o_mrg_k_item/empty, i_mrg_k_read   merger side k view and read strobe
//   i_mrg_out_write                    merger output-write strobe (observed)
//   o_busy                             in MERGE or NEXT
//   o_done                             one-cycle completion pulse
//   o_run_idx                          current run pair index
//   o_err                              sticky protocol error
// ---------------------------------------------------------------------------
module merge_run_sequencer
   import merge_pkg::*;
#(
   parameter int                 DATA_W   = DATA_W_DEF,
   parameter int                 CNT_W    = CNT_W_DEF,
   parameter logic [DATA_W-1:0]  SENTINEL = {DATA_W{1'b1}}
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [CNT_W-1:0]  i_run_len,
   input  logic [CNT_W-1:0]  i_num_runs,
   input  logic [DATA_W-1:0] i_fifo_1_item,
   input  logic              i_fifo_1_empty,
   output logic              o_fifo_1_read,
   input  logic [DATA_W-1:0] i_fifo_2_item,
   input  logic              i_fifo_2_empty,
   output logic              o_fifo_2_read,
   output logic [DATA_W-1:0] o_mrg_1_item,
   output logic              o_mrg_1_empty,
   input  logic              i_mrg_1_read,
   output logic [DATA_W-1:0] o_mrg_2_item,
   output logic              o_mrg_2_empty,
   input  logic              i_mrg_2_read,
   input  logic              i_mrg_out_write,
   output logic              o_busy,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_run_idx,
   output logic              o_err
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] run_len_q, num_runs_q, run_idx;
   logic [CNT_W:0]   out_cnt, out_cnt_inc, pair_total;
   logic             start_ok, in_merge, in_next, clear_cnt;
   logic             pair_end, last_pair;
   logic             act_1, act_2, err_1, err_2, err_set;

   assign start_ok    = (state == IDLE) && i_start;
   assign in_merge    = (state == MERGE);
   assign in_next     = (state == NEXT);
   assign clear_cnt   = start_ok || in_next;

   // A pair is complete once the merger has written both runs: 2*run_len.
   assign out_cnt_inc = out_cnt + (CNT_W+1)'(1);
   assign pair_total  = {run_len_q, 1'b0};
   assign pair_end    = in_merge && i_mrg_out_write && (out_cnt_inc == pair_total);
   assign last_pair   = (run_idx == (num_runs_q - CNT_W'(1)));

   assign err_set     = err_1 || err_2 || (i_mrg_out_write && !in_merge);

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = ((i_run_len == '0) || (i_num_runs == '0)) ? DONE : MERGE;
            end
         end
         MERGE: begin
            o_busy = 1'b1;
            if (pair_end) begin
               state_nxt = last_pair ? DONE : NEXT;
            end
         end
         NEXT: begin
            o_busy    = 1'b1;
            state_nxt = MERGE;
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         run_len_q  <= '0;
         num_runs_q <= '0;
         out_cnt    <= '0;
         run_idx    <= '0;
         o_err      <= 1'b0;
      end else begin
         if (start_ok) begin
            run_len_q  <= i_run_len;
            num_runs_q <= i_num_runs;
         end

         if (clear_cnt) begin
            out_cnt <= '0;
         end else if (in_merge && i_mrg_out_write) begin
            out_cnt <= out_cnt_inc;
         end

         if (start_ok) begin
            run_idx <= '0;
         end else if (in_next) begin
            run_idx <= run_idx + CNT_W'(1);
         end

         if (start_ok) begin
            o_err <= 1'b0;
         end else if (err_set) begin
            o_err <= 1'b1;
         end
      end
   end

   assign o_run_idx = run_idx;

   // ---------------- side gates ----------------
   run_side_gate #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SENTINEL(SENTINEL)) u_side_1 (
      .clk          (i_clk),
      .rst_n        (i_rst_n),
      .run_len      (run_len_q),
      .clear        (clear_cnt),
      .enable       (in_merge),
      .other_active (act_2),
      .fifo_item    (i_fifo_1_item),
      .fifo_empty   (i_fifo_1_empty),
      .fifo_read    (o_fifo_1_read),
      .mrg_item     (o_mrg_1_item),
      .mrg_empty    (o_mrg_1_empty),
      .mrg_read     (i_mrg_1_read),
      .active       (act_1),
      .err          (err_1)
   );

   run_side_gate #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SENTINEL(SENTINEL)) u_side_2 (
      .clk          (i_clk),
      .rst_n        (i_rst_n),
      .run_len      (run_len_q),
      .clear        (clear_cnt),
      .enable       (in_merge),
      .other_active (act_1),
      .fifo_item    (i_fifo_2_item),
      .fifo_empty   (i_fifo_2_empty),
      .fifo_read    (o_fifo_2_read),
      .mrg_item     (o_mrg_2_item),
      .mrg_empty    (o_mrg_2_empty),
      .mrg_read     (i_mrg_2_read),
      .active       (act_2),
      .err          (err_2)
   );

endmodule

// File: tb/tb_merge_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_merge_run_sequencer
// Drives the sequencer with two FIFO models and a simple behavioural merger.
// Expected merger output per run pair is the sorted union of the two runs,
// tagged with the run pair index; a monitor pops and compares on every
// merger write.
// ---------------------------------------------------------------------------
module tb_merge_run_sequencer;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   localparam int W      = CNT_W + DATA_W;

   // ---------------- clock / DUT signals ----------------
   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   logic              i_rst_n, i_start;
   logic [CNT_W-1:0]  i_run_len, i_num_runs;
   logic [DATA_W-1:0] i_fifo_1_item, i_fifo_2_item;
   logic              i_fifo_1_empty, i_fifo_2_empty;
   logic              o_fifo_1_read, o_fifo_2_read;
   logic [DATA_W-1:0] o_mrg_1_item, o_mrg_2_item;
   logic              o_mrg_1_empty, o_mrg_2_empty;
   logic              i_mrg_1_read, i_mrg_2_read, i_mrg_out_write;
   logic              o_busy, o_done, o_err;
   logic [CNT_W-1:0]  o_run_idx;

   merge_run_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .i_run_len(i_run_len), .i_num_runs(i_num_runs),
      .i_fifo_1_item(i_fifo_1_item), .i_fifo_1_empty(i_fifo_1_empty), .o_fifo_1_read(o_fifo_1_read),
      .i_fifo_2_item(i_fifo_2_item), .i_fifo_2_empty(i_fifo_2_empty), .o_fifo_2_read(o_fifo_2_read),
      .o_mrg_1_item(o_mrg_1_item), .o_mrg_1_empty(o_mrg_1_empty), .i_mrg_1_read(i_mrg_1_read),
      .o_mrg_2_item(o_mrg_2_item), .o_mrg_2_empty(o_mrg_2_empty), .i_mrg_2_read(i_mrg_2_read),
      .i_mrg_out_write(i_mrg_out_write),
      .o_busy(o_busy), .o_done(o_done), .o_run_idx(o_run_idx), .o_err(o_err)
   );

   // ---------------- shared bench state ----------------
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [W-1:0]      exp_q[$];
   logic [DATA_W-1:0] f1_q[$], f2_q[$];
   logic [DATA_W-1:0] src1[$], src2[$];

   bit pause = 1'b1, force_write = 1'b0;
   int stall_pct = 0, empty_pct = 0, hold2_until = 0;

   bit                model_write = 1'b0;
   logic [DATA_W-1:0] model_data = '0;
   bit                pop1 = 1'b0, pop2 = 1'b0;
   int                pops1 = 0, pops2 = 0;

   int writes = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
   bit prev_done = 1'b0;

   int p1_0, p2_0, d0, w0, start_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- FIFO + merger model ----------------
   initial begin
      i_fifo_1_item = '0; i_fifo_2_item = '0;
      i_fifo_1_empty = 1'b1; i_fifo_2_empty = 1'b1;
      i_mrg_1_read = 1'b0; i_mrg_2_read = 1'b0; i_mrg_out_write = 1'b0;
      forever begin
         @(negedge clk);
         if (pop1) begin pops1++; if (f1_q.size() > 0) void'(f1_q.pop_front()); end
         if (pop2) begin pops2++; if (f2_q.size() > 0) void'(f2_q.pop_front()); end
         i_fifo_1_item  = (f1_q.size() > 0) ? f1_q[0] : '0;
         i_fifo_2_item  = (f2_q.size() > 0) ? f2_q[0] : '0;
         i_fifo_1_empty = (f1_q.size() == 0) || (int'($urandom_range(99)) < empty_pct);
         i_fifo_2_empty = (f2_q.size() == 0) || (int'($urandom_range(99)) < empty_pct)
                          || (cyc < hold2_until);
         i_mrg_1_read = 1'b0; i_mrg_2_read = 1'b0;
         model_write  = 1'b0;
         #1;
         i_mrg_out_write = force_write;
         if (!pause && !o_mrg_1_empty && !o_mrg_2_empty &&
             int'($urandom_range(99)) >= stall_pct) begin
            if (o_mrg_1_item <= o_mrg_2_item) begin
               i_mrg_1_read = 1'b1; model_data = o_mrg_1_item;
            end else begin
               i_mrg_2_read = 1'b1; model_data = o_mrg_2_item;
            end
            i_mrg_out_write = 1'b1;
            model_write     = 1'b1;
         end
         #1;
         pop1 = o_fifo_1_read;
         pop2 = o_fifo_2_read;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         #3;
         if (o_done) begin
            check("done_single_cycle", 64'(prev_done), 64'(0));
            done_cnt++;
            done_cyc = cyc;
         end
         prev_done = o_done;
         if (model_write) begin
            writes++;
            last_wr_cyc = cyc;
            check("busy_on_write", 64'(o_busy), 64'(1));
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_output: got %0h expected none", model_data);
            end else begin
               exp = exp_q.pop_front();
               check("merge_out", 64'({o_run_idx, model_data}), 64'(exp));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_src(input int n, input int a[8], input int b[8]);
      src1.delete(); src2.delete();
      for (int i = 0; i < n; i++) begin
         src1.push_back(DATA_W'(a[i]));
         src2.push_back(DATA_W'(b[i]));
      end
   endtask

   task automatic fill_random(input int len, input int n);
      logic [DATA_W-1:0] run[$];
      src1.delete(); src2.delete();
      for (int s = 0; s < 2; s++) begin
         for (int r = 0; r < n; r++) begin
            run.delete();
            for (int i = 0; i < len; i++) run.push_back(DATA_W'($urandom_range(0, 200)));
            run.sort();
            foreach (run[i]) begin
               if (s == 0) src1.push_back(run[i]);
               else        src2.push_back(run[i]);
            end
         end
      end
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      pause = 1'b1; i_rst_n = 1'b0; i_start = 1'b0;
      @(negedge clk);
      #2;
      if (chk) begin
         check("rst_busy",    64'(o_busy), 64'(0));
         check("rst_done",    64'(o_done), 64'(0));
         check("rst_err",     64'(o_err), 64'(0));
         check("rst_run_idx", 64'(o_run_idx), 64'(0));
         check("rst_empty_1", 64'(o_mrg_1_empty), 64'(1));
         check("rst_empty_2", 64'(o_mrg_2_empty), 64'(1));
      end
      i_rst_n = 1'b1;
      exp_q.delete(); f1_q.delete(); f2_q.delete();
      pause = 1'b0;
   endtask

   // Loads FIFOs from src1/src2, queues the expected merge, pulses start.
   task automatic launch(input int len, input int n);
      logic [DATA_W-1:0] pair[$];
      @(negedge clk);
      f1_q = src1; f2_q = src2;
      for (int r = 0; r < n; r++) begin
         pair.delete();
         for (int i = 0; i < len; i++) begin
            pair.push_back(src1[r*len+i]);
            pair.push_back(src2[r*len+i]);
         end
         pair.sort();
         foreach (pair[i]) exp_q.push_back({CNT_W'(r), pair[i]});
      end
      p1_0 = pops1; p2_0 = pops2; d0 = done_cnt; w0 = writes;
      i_run_len = CNT_W'(len); i_num_runs = CNT_W'(n); i_start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      i_start = 1'b0;
      #2;
      check("err_clear_on_start", 64'(o_err), 64'(0));
      check("busy_after_start",   64'(o_busy), 64'((len > 0) && (n > 0)));
   endtask

   task automatic finish_job(input int len, input int n);
      int t = 0;
      while (done_cnt == d0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      #2;
      check("done_seen", 64'(done_cnt != d0), 64'(1));
      if (done_cnt == d0) begin
         do_reset(1'b0);
      end else begin
         check("done_count",   64'(done_cnt - d0), 64'(1));
         check("exp_drained",  64'(exp_q.size()), 64'(0));
         check("pops_side_1",  64'(pops1 - p1_0), 64'(len * n));
         check("pops_side_2",  64'(pops2 - p2_0), 64'(len * n));
         check("err_after_job", 64'(o_err), 64'(0));
         check("idle_after_done", 64'(o_busy), 64'(0));
         if (len * n > 0) check("done_lat_after_last_write", 64'(done_cyc - last_wr_cyc), 64'(1));
         else             check("done_lat_after_start",      64'(done_cyc - start_cyc), 64'(1));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      i_rst_n = 1'b0; i_start = 1'b0; i_run_len = '0; i_num_runs = '0;
      repeat (2) @(negedge clk);
      do_reset(1'b1);

      // Single pair, interleaved keys.
      set_src(4, '{1,3,5,7,0,0,0,0}, '{2,4,6,8,0,0,0,0});
      launch(4, 1); finish_job(4, 1);

      // Two pairs; side 2 runs out first in pair 0.
      set_src(4, '{1,9,2,3,0,0,0,0}, '{5,6,7,8,0,0,0,0});
      launch(2, 2); finish_job(2, 2);

      // FIFO 2 late: merger must stall, not see a sentinel.
      set_src(3, '{1,2,3,0,0,0,0,0}, '{4,5,6,0,0,0,0,0});
      hold2_until = cyc + 7;
      launch(3, 1);
      repeat (3) @(negedge clk);
      #2;
      check("stall_while_fifo2_empty", 64'(writes - w0), 64'(0));
      finish_job(3, 1);
      hold2_until = 0;

      // Reset in the middle of a pair, then a clean rerun.
      set_src(4, '{1,3,5,7,0,0,0,0}, '{2,4,6,8,0,0,0,0});
      launch(4, 1);
      for (int t = 0; t < 200 && (writes - w0) < 3; t++) @(negedge clk);
      check("mid_run_writes", 64'((writes - w0) >= 3), 64'(1));
      do_reset(1'b1);
      launch(4, 1); finish_job(4, 1);

      // Zero-length jobs go straight to DONE with no reads.
      src1.delete(); src2.delete();
      launch(0, 3); finish_job(0, 3);
      launch(2, 0); finish_job(2, 0);

      // Stray output write in IDLE sets a sticky error.
      @(negedge clk);
      force_write = 1'b1;
      @(negedge clk);
      force_write = 1'b0;
      #2;
      check("err_set_idle_write", 64'(o_err), 64'(1));
      repeat (3) @(negedge clk);
      #2;
      check("err_sticky", 64'(o_err), 64'(1));

      // Randomized jobs with merger stalls and FIFO bubbles.
      for (int j = 0; j < 10; j++) begin
         int len, n;
         len = $urandom_range(1, 6);
         n   = $urandom_range(1, 4);
         stall_pct = $urandom_range(0, 30);
         empty_pct = $urandom_range(0, 30);
         fill_random(len, n);
         launch(len, n);
         finish_job(len, n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
      $fatal(1, "bench did not finish");
   end

endmodule
